fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage.
- Decides every cycle whether the PC register loads, and from which source: sequential, branch or jump.
- Generates IF/ID load and flush, drives the instruction-memory request, and holds branch/jump redirects that arrive while the memory has not returned the current fetch.
- Sits between the hazard/branch logic in ID and the IF stage; its PCLd, PCSrc and redirAddr outputs drive the IF stage's PCLd, PCSrc, branchAddress and jAddress inputs.

Parameters:
- ADDR_W, 32, width of PC and target addresses.
- BOOT_CYCLES, 2, cycles after reset release before the first fetch request (range 1..15).
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- stall  in  1  load-use hazard from ID; hold PC and IF/ID.
- branchTaken  in  1  branch in ID resolved taken.
- jump  in  1  jump in ID.
- branchAddress  in  ADDR_W  branch target, valid with branchTaken.
- jAddress  in  ADDR_W  jump target, valid with jump.
- imemReady  in  1  instruction memory returns a valid word for the current PC this cycle.
- imemReq  out  1  fetch request to instruction memory.
- PCLd  out  1  PC register load enable.
- PCSrc  out  2  0 = PC+4, 1 = branch redirect, 2 = jump redirect; 3 is never driven.
- redirAddr  out  ADDR_W  redirect target; wired to both IF target inputs.
- IFIDLd  out  1  IF/ID register load enable.
- IFIDFlush  out  1  IF/ID clear to bubble; flush overrides load at the register.
- bubbleCnt  out  CNT_W  saturating count of flush cycles.

Behaviour:
- States: BOOT, RUN, REDIR_PEND.
- Reset (rst=0 at a clock edge, in any state):
  - state=BOOT, boot counter=0, pending target=0, pending source=0, bubbleCnt=0.
  - Any pending redirect is discarded.
- Output values in reset/BOOT: PCLd=0, PCSrc=0, redirAddr=0, imemReq=0, IFIDLd=1, IFIDFlush=1.
- BOOT: counter increments each cycle; when it reaches BOOT_CYCLES-1, go to RUN. Flush cycles in BOOT are not counted.
- RUN: imemReq=1. Outputs are combinational from inputs, evaluated in this priority order:
  1. stall=1 → PCLd=0, IFIDLd=0, IFIDFlush=0. branchTaken/jump are ignored (ID re-presents them next cycle). Applies regardless of imemReady.
  2. branchTaken or jump → IFIDLd=1, IFIDFlush=1. If both are asserted, branch wins (PCSrc=1, branchAddress).
     - imemReady=1 → PCLd=1, PCSrc=1 (branch) or 2 (jump), redirAddr = live target; stay in RUN. Zero added latency.
     - imemReady=0 → PCLd=0, PCSrc=0; latch target and source; next state REDIR_PEND.
  3. imemReady=1 → PCLd=1, PCSrc=0, IFIDLd=1, IFIDFlush=0.
  4. imemReady=0 → PCLd=0, IFIDLd=1, IFIDFlush=1 (bubble).
- In RUN, outside items 2–3, redirAddr = pending register (0 unless just latched).
- REDIR_PEND: imemReq=1, IFIDLd=1, IFIDFlush=1 every cycle; stall, branchTaken and jump are ignored.
  - imemReady=0 → PCLd=0; stay.
  - imemReady=1 → the returned word is wrong-path and is discarded. PCLd=1, PCSrc = held source, redirAddr = held target; next state RUN.
- bubbleCnt: increments on every cycle with IFIDFlush=1 in RUN or REDIR_PEND; saturates at all-ones (no wrap).
- Invariants:
  - PCLd=1 implies imemReady=1.
  - IFIDFlush=1 implies IFIDLd=1.
  - PCSrc≠0 only when PCLd=1.

Decomposition:
- Shared pipeline package holds:
  - PCSrc encodings: PCSRC_SEQ=0, PCSRC_BR=1, PCSRC_J=2.
  - State encodings: BOOT, RUN, REDIR_PEND.
  - Default ADDR_W.
- One natural sub-module: sat_counter (CNT_W-wide, enable, synchronous active-low clear), reused by other performance counters.
- The state machine and pending-redirect registers stay in fetch_ctrl.

Test Plan:
- Reset then release with BOOT_CYCLES=2, imemReady=1 → imemReq=0 for 2 cycles, then PCLd=1, PCSrc=0 every cycle; bubbleCnt=0.
- RUN, imemReady=1, branchTaken=1, branchAddress=0x40 → same cycle: PCLd=1, PCSrc=1, redirAddr=0x40, IFIDFlush=1; bubbleCnt=1.
- RUN, imemReady=0, jump=1, jAddress=0x100, then imemReady=0 for 2 cycles, then 1 → PCLd=0 for 3 cycles with IFIDFlush=1; on the 4th cycle PCLd=1, PCSrc=2, redirAddr=0x100; bubbleCnt=4.
- stall=1 together with branchTaken=1 and imemReady=1 → PCLd=0, IFIDLd=0, IFIDFlush=0. Next cycle stall=0, branch still held → redirect taken.
- Both branchTaken and jump asserted, branchAddress=0x20, jAddress=0x80, imemReady=1 → PCSrc=1, redirAddr=0x20.
- REDIR_PEND entered, then rst=0 for one cycle → pending cleared, BOOT re-entered, bubbleCnt=0, first fetch after BOOT has PCSrc=0.
- With CNT_W=2 and 5 consecutive bubbles → bubbleCnt stops at 3.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types: PC source encodings, controller states
// and the default address width.
package fetch_ctrl_pkg;

    localparam int DEF_ADDR_W = 32;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'd0,
        PCSRC_BR  = 2'd1,
        PCSRC_J   = 2'd2
    } pcsrc_e;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        REDIR_PEND = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // count enabled cycles, stick at the maximum value
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing: chooses PC source, drives IF/ID load/flush and
// the imem request, and parks redirects while a fetch is outstanding.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branchTaken,
    input  logic              jump,
    input  logic [ADDR_W-1:0] branchAddress,
    input  logic [ADDR_W-1:0] jAddress,
    input  logic              imemReady,
    output logic              imemReq,
    output logic              PCLd,
    output logic [1:0]        PCSrc,
    output logic [ADDR_W-1:0] redirAddr,
    output logic              IFIDLd,
    output logic              IFIDFlush,
    output logic [CNT_W-1:0]  bubbleCnt
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic [3:0]        boot_cnt;
    logic [ADDR_W-1:0] pend_addr;
    pcsrc_e            pend_src;
    pcsrc_e            pcsrc;
    pcsrc_e            live_src;
    logic [ADDR_W-1:0] live_addr;
    logic              latch;
    logic              clr_pend;
    logic              bub_en;

    // branch wins when ID presents both a branch and a jump
    assign live_src  = branchTaken ? PCSRC_BR : PCSRC_J;
    assign live_addr = branchTaken ? branchAddress : jAddress;

    // next state and all fetch-control outputs
    always_comb begin
        state_nxt = state;
        imemReq   = 1'b0;
        PCLd      = 1'b0;
        pcsrc     = PCSRC_SEQ;
        redirAddr = '0;
        IFIDLd    = 1'b1;
        IFIDFlush = 1'b1;
        latch     = 1'b0;
        clr_pend  = 1'b0;
        if (rst) begin
            unique case (state)
                BOOT: begin
                    if (boot_cnt == BOOT_LAST) state_nxt = RUN;
                end
                RUN: begin
                    imemReq   = 1'b1;
                    redirAddr = pend_addr;
                    if (stall) begin
                        IFIDLd    = 1'b0;
                        IFIDFlush = 1'b0;
                    end else if (branchTaken || jump) begin
                        if (imemReady) begin
                            PCLd      = 1'b1;
                            pcsrc     = live_src;
                            redirAddr = live_addr;
                        end else begin
                            latch     = 1'b1;
                            state_nxt = REDIR_PEND;
                        end
                    end else if (imemReady) begin
                        PCLd      = 1'b1;
                        IFIDFlush = 1'b0;
                    end
                end
                REDIR_PEND: begin
                    imemReq   = 1'b1;
                    redirAddr = pend_addr;
                    if (imemReady) begin
                        PCLd      = 1'b1;
                        pcsrc     = pend_src;
                        clr_pend  = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    assign PCSrc = pcsrc;

    // state, boot delay and parked redirect target
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            pend_addr <= '0;
            pend_src  <= PCSRC_SEQ;
        end else begin
            state <= state_nxt;
            if (state == BOOT && boot_cnt != BOOT_LAST) begin
                boot_cnt <= boot_cnt + 4'd1;
            end
            if (latch) begin
                pend_addr <= live_addr;
                pend_src  <= live_src;
            end else if (clr_pend) begin
                pend_addr <= '0;
                pend_src  <= PCSRC_SEQ;
            end
        end
    end

    assign bub_en = rst && (state != BOOT) && IFIDFlush;

    sat_counter #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk(clk),
        .rst(rst),
        .en (bub_en),
        .cnt(bubbleCnt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; a second instance with a 2-bit
// bubble counter checks saturation.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branchTaken;
    logic        jump;
    logic [31:0] branchAddress;
    logic [31:0] jAddress;
    logic        imemReady;
    logic        imemReq;
    logic        PCLd;
    logic [1:0]  PCSrc;
    logic [31:0] redirAddr;
    logic        IFIDLd;
    logic        IFIDFlush;
    logic [15:0] bubbleCnt;

    logic        req2;
    logic        pcld2;
    logic [1:0]  pcsrc2;
    logic [31:0] redir2;
    logic        ifidld2;
    logic        flush2;
    logic [1:0]  bub2;

    int vec = 0;
    int miscmp = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDR_W(32), .BOOT_CYCLES(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branchTaken(branchTaken), .jump(jump),
        .branchAddress(branchAddress), .jAddress(jAddress),
        .imemReady(imemReady), .imemReq(imemReq),
        .PCLd(PCLd), .PCSrc(PCSrc), .redirAddr(redirAddr),
        .IFIDLd(IFIDLd), .IFIDFlush(IFIDFlush),
        .bubbleCnt(bubbleCnt)
    );

    fetch_ctrl #(
        .ADDR_W(32), .BOOT_CYCLES(2), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst(rst), .stall(stall),
        .branchTaken(branchTaken), .jump(jump),
        .branchAddress(branchAddress), .jAddress(jAddress),
        .imemReady(imemReady), .imemReq(req2),
        .PCLd(pcld2), .PCSrc(pcsrc2), .redirAddr(redir2),
        .IFIDLd(ifidld2), .IFIDFlush(flush2),
        .bubbleCnt(bub2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0;
        branchTaken = 1'b0;
        jump = 1'b0;
        branchAddress = '0;
        jAddress = '0;
    endtask

    task automatic boot();
        idle_inputs();
        imemReady = 1'b1;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        imemReady = 1'b1;
        rst = 1'b0;
        step();
        step();
        @(negedge clk);
        vec++; if (imemReq !== 1'b0) begin miscmp++; $display("FAIL rst_req got %b want 0", imemReq); end
        vec++; if (PCLd !== 1'b0) begin miscmp++; $display("FAIL rst_pcld got %b want 0", PCLd); end
        vec++; if ({IFIDLd, IFIDFlush} !== 2'b11) begin miscmp++; $display("FAIL rst_ifid got %b want 11", {IFIDLd, IFIDFlush}); end
        vec++; if (redirAddr !== 32'h0) begin miscmp++; $display("FAIL rst_redir got %h want 0", redirAddr); end
        vec++; if (bubbleCnt !== 16'd0) begin miscmp++; $display("FAIL rst_bub got %0d want 0", bubbleCnt); end
        step();
        rst = 1'b1;
        @(negedge clk);
        vec++; if (imemReq !== 1'b0) begin miscmp++; $display("FAIL boot0_req got %b want 0", imemReq); end
        step();
        @(negedge clk);
        vec++; if (imemReq !== 1'b0) begin miscmp++; $display("FAIL boot1_req got %b want 0", imemReq); end
        vec++; if (PCLd !== 1'b0) begin miscmp++; $display("FAIL boot1_pcld got %b want 0", PCLd); end
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            vec++; if ({imemReq, PCLd, PCSrc, IFIDFlush} !== 5'b11000) begin miscmp++; $display("FAIL run_seq%0d got %b want 11000", i, {imemReq, PCLd, PCSrc, IFIDFlush}); end
        end
        vec++; if (bubbleCnt !== 16'd0) begin miscmp++; $display("FAIL run_bub got %0d want 0", bubbleCnt); end
    endtask

    task automatic test_branch_hit();
        boot();
        branchTaken = 1'b1;
        branchAddress = 32'h40;
        imemReady = 1'b1;
        @(negedge clk);
        vec++; if ({PCLd, PCSrc} !== 3'b101) begin miscmp++; $display("FAIL br_pc got %b want 101", {PCLd, PCSrc}); end
        vec++; if (redirAddr !== 32'h40) begin miscmp++; $display("FAIL br_addr got %h want 40", redirAddr); end
        vec++; if ({IFIDLd, IFIDFlush} !== 2'b11) begin miscmp++; $display("FAIL br_flush got %b want 11", {IFIDLd, IFIDFlush}); end
        step();
        idle_inputs();
        @(negedge clk);
        vec++; if (bubbleCnt !== 16'd1) begin miscmp++; $display("FAIL br_bub got %0d want 1", bubbleCnt); end
        vec++; if ({PCLd, PCSrc} !== 3'b100) begin miscmp++; $display("FAIL br_after got %b want 100", {PCLd, PCSrc}); end
    endtask

    task automatic test_jump_pend();
        boot();
        jump = 1'b1;
        jAddress = 32'h100;
        imemReady = 1'b0;
        @(negedge clk);
        vec++; if ({PCLd, PCSrc, IFIDFlush} !== 4'b0001) begin miscmp++; $display("FAIL jp_c0 got %b want 0001", {PCLd, PCSrc, IFIDFlush}); end
        step();
        idle_inputs();
        @(negedge clk);
        vec++; if ({PCLd, IFIDFlush} !== 2'b01) begin miscmp++; $display("FAIL jp_c1 got %b want 01", {PCLd, IFIDFlush}); end
        step();
        @(negedge clk);
        vec++; if ({PCLd, IFIDFlush} !== 2'b01) begin miscmp++; $display("FAIL jp_c2 got %b want 01", {PCLd, IFIDFlush}); end
        step();
        imemReady = 1'b1;
        @(negedge clk);
        vec++; if ({PCLd, PCSrc, IFIDFlush} !== 4'b1101) begin miscmp++; $display("FAIL jp_c3 got %b want 1101", {PCLd, PCSrc, IFIDFlush}); end
        vec++; if (redirAddr !== 32'h100) begin miscmp++; $display("FAIL jp_addr got %h want 100", redirAddr); end
        step();
        @(negedge clk);
        vec++; if (bubbleCnt !== 16'd4) begin miscmp++; $display("FAIL jp_bub got %0d want 4", bubbleCnt); end
        vec++; if ({PCLd, PCSrc, IFIDFlush} !== 4'b1000) begin miscmp++; $display("FAIL jp_back got %b want 1000", {PCLd, PCSrc, IFIDFlush}); end
    endtask

    task automatic test_stall();
        boot();
        stall = 1'b1;
        branchTaken = 1'b1;
        branchAddress = 32'h44;
        imemReady = 1'b1;
        @(negedge clk);
        vec++; if ({PCLd, IFIDLd, IFIDFlush} !== 3'b000) begin miscmp++; $display("FAIL st_hold got %b want 000", {PCLd, IFIDLd, IFIDFlush}); end
        vec++; if (PCSrc !== 2'd0) begin miscmp++; $display("FAIL st_src got %0d want 0", PCSrc); end
        step();
        stall = 1'b0;
        @(negedge clk);
        vec++; if ({PCLd, PCSrc, IFIDFlush} !== 4'b1011) begin miscmp++; $display("FAIL st_redir got %b want 1011", {PCLd, PCSrc, IFIDFlush}); end
        vec++; if (redirAddr !== 32'h44) begin miscmp++; $display("FAIL st_addr got %h want 44", redirAddr); end
        step();
        idle_inputs();
        @(negedge clk);
        vec++; if (bubbleCnt !== 16'd1) begin miscmp++; $display("FAIL st_bub got %0d want 1", bubbleCnt); end
    endtask

    task automatic test_both();
        boot();
        branchTaken = 1'b1;
        jump = 1'b1;
        branchAddress = 32'h20;
        jAddress = 32'h80;
        imemReady = 1'b1;
        @(negedge clk);
        vec++; if ({PCLd, PCSrc} !== 3'b101) begin miscmp++; $display("FAIL both_src got %b want 101", {PCLd, PCSrc}); end
        vec++; if (redirAddr !== 32'h20) begin miscmp++; $display("FAIL both_addr got %h want 20", redirAddr); end
        imemReady = 1'b0;
        branchAddress = 32'h24;
        step();
        idle_inputs();
        jAddress = 32'h88;
        imemReady = 1'b1;
        @(negedge clk);
        vec++; if ({PCLd, PCSrc} !== 3'b101) begin miscmp++; $display("FAIL both_pend got %b want 101", {PCLd, PCSrc}); end
        vec++; if (redirAddr !== 32'h24) begin miscmp++; $display("FAIL both_paddr got %h want 24", redirAddr); end
    endtask

    task automatic test_reset_pend();
        boot();
        jump = 1'b1;
        jAddress = 32'h100;
        imemReady = 1'b0;
        step();
        idle_inputs();
        @(negedge clk);
        vec++; if ({imemReq, PCLd, IFIDFlush} !== 3'b101) begin miscmp++; $display("FAIL rp_pend got %b want 101", {imemReq, PCLd, IFIDFlush}); end
        step();
        rst = 1'b0;
        @(negedge clk);
        vec++; if ({imemReq, PCLd, PCSrc} !== 4'b0000) begin miscmp++; $display("FAIL rp_rst got %b want 0000", {imemReq, PCLd, PCSrc}); end
        step();
        rst = 1'b1;
        imemReady = 1'b1;
        @(negedge clk);
        vec++; if (imemReq !== 1'b0) begin miscmp++; $display("FAIL rp_boot got %b want 0", imemReq); end
        vec++; if (bubbleCnt !== 16'd0) begin miscmp++; $display("FAIL rp_bub got %0d want 0", bubbleCnt); end
        step();
        step();
        @(negedge clk);
        vec++; if ({imemReq, PCLd, PCSrc} !== 4'b1100) begin miscmp++; $display("FAIL rp_first got %b want 1100", {imemReq, PCLd, PCSrc}); end
        vec++; if (redirAddr !== 32'h0) begin miscmp++; $display("FAIL rp_addr got %h want 0", redirAddr); end
    endtask

    task automatic test_saturate();
        boot();
        imemReady = 1'b0;
        @(negedge clk);
        vec++; if ({PCLd, IFIDLd, IFIDFlush} !== 3'b011) begin miscmp++; $display("FAIL sat_bubble got %b want 011", {PCLd, IFIDLd, IFIDFlush}); end
        step();
        step();
        step();
        @(negedge clk);
        vec++; if (bub2 !== 2'd3) begin miscmp++; $display("FAIL sat_at3 got %0d want 3", bub2); end
        step();
        step();
        imemReady = 1'b1;
        @(negedge clk);
        vec++; if (bub2 !== 2'd3) begin miscmp++; $display("FAIL sat_hold got %0d want 3", bub2); end
        vec++; if (bubbleCnt !== 16'd5) begin miscmp++; $display("FAIL sat_wide got %0d want 5", bubbleCnt); end
    endtask

    initial begin
        idle_inputs();
        imemReady = 1'b1;
        rst = 1'b0;
        test_reset();
        test_branch_hit();
        test_jump_pend();
        test_stall();
        test_both();
        test_reset_pend();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
